// File: rtl/button_debounce.sv
// ============================================================================
//  Module   : button_debounce
//  Purpose  : N-channel pushbutton conditioner: 2-FF sync, debounce, and
//             press / release / auto-repeat event pulses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce #(
  parameter int N               = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 16000000,
  parameter int REPEAT_CYCLES   = 4000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pin,
  output logic [N-1:0] pressed,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] repeat_pulse,
  output logic         any_event
);

  localparam logic c_ACT    = (ACTIVE_LOW != 0);
  localparam int   c_DW     = $clog2(DEBOUNCE_CYCLES);
  localparam int   c_HMAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int   c_HW     = $clog2(c_HMAX + 1);
  localparam logic c_REP_EN = (REPEAT_CYCLES > 0);

  localparam logic [c_DW-1:0] c_DLAST = c_DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_HW-1:0] c_HLAST = c_HW'(HOLD_CYCLES - 1);
  localparam logic [c_HW-1:0] c_RLAST = c_HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic            r_s1, r_s2;
    logic            r_pressed;
    logic            r_press_p, r_rel_p, r_rep_p;
    logic            r_spent;
    logic [c_DW-1:0] r_dcnt;
    logic [c_HW-1:0] r_hcnt;
    state_t          r_state;
    logic            w_level;
    logic            w_accept;

    assign w_level  = r_s2 ^ c_ACT;
    assign w_accept = (w_level != r_pressed) && (r_dcnt == c_DLAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1      <= c_ACT;
        r_s2      <= c_ACT;
        r_pressed <= 1'b0;
        r_press_p <= 1'b0;
        r_rel_p   <= 1'b0;
        r_rep_p   <= 1'b0;
        r_spent   <= 1'b0;
        r_dcnt    <= '0;
        r_hcnt    <= '0;
        r_state   <= S_IDLE;
      end else begin
        r_s1      <= pin[i];
        r_s2      <= r_s1;
        r_press_p <= 1'b0;
        r_rel_p   <= 1'b0;
        r_rep_p   <= 1'b0;

        if (w_level == r_pressed) begin
          r_dcnt <= '0;
        end else if (w_accept) begin
          r_dcnt    <= '0;
          r_pressed <= w_level;
          r_press_p <= w_level;
          r_rel_p   <= ~w_level;
        end else begin
          r_dcnt <= r_dcnt + c_DW'(1);
        end

        // An accepted release overrides any repeat due on the same edge.
        if (w_accept && !w_level) begin
          r_state <= S_IDLE;
          r_hcnt  <= '0;
          r_spent <= 1'b0;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_accept) begin
                r_state <= S_HOLD;
                r_hcnt  <= '0;
                r_spent <= 1'b0;
              end
            end
            S_HOLD: begin
              // r_spent freezes the hold counter once the single repeat fired.
              if (!r_spent) begin
                if (r_hcnt == c_HLAST) begin
                  r_rep_p <= 1'b1;
                  r_hcnt  <= '0;
                  if (c_REP_EN) r_state <= S_REPEAT;
                  else          r_spent <= 1'b1;
                end else begin
                  r_hcnt <= r_hcnt + c_HW'(1);
                end
              end
            end
            S_REPEAT: begin
              if (r_hcnt == c_RLAST) begin
                r_rep_p <= 1'b1;
                r_hcnt  <= '0;
              end else begin
                r_hcnt <= r_hcnt + c_HW'(1);
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_hcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign pressed[i]       = r_pressed;
    assign press_pulse[i]   = r_press_p;
    assign release_pulse[i] = r_rel_p;
    assign repeat_pulse[i]  = r_rep_p;
  end

  assign any_event = |{press_pulse, release_pulse, repeat_pulse};

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
// ============================================================================
//  Module   : tb_button_debounce
//  Purpose  : Directed self-checking bench for button_debounce.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pin;
  logic [1:0] pressed, press_pulse, release_pulse, repeat_pulse;
  logic       any_event;
  logic [1:0] pin_nr;
  logic [1:0] pressed_nr, press_nr, release_nr, repeat_nr;
  logic       any_nr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  button_debounce #(
    .N(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .pin(pin),
    .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .any_event(any_event)
  );

  button_debounce #(
    .N(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(0)
  ) u_dut_norep (
    .clk(clk), .rst_n(rst_n), .pin(pin_nr),
    .pressed(pressed_nr), .press_pulse(press_nr), .release_pulse(release_nr),
    .repeat_pulse(repeat_nr), .any_event(any_nr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; return 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".pressed"}, 32'(pressed), 32'd0);
    check({tag, ".pulses"}, 32'({press_pulse, release_pulse, repeat_pulse}), 32'd0);
    check({tag, ".any"}, 32'(any_event), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    pin    = 2'b11;
    pin_nr = 2'b11;
    tick(3);
    check_quiet("reset");
    check("reset.nr", 32'({pressed_nr, press_nr, repeat_nr, any_nr}), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Clean press on channel 0, held into auto-repeat, released on a repeat slot
    pin = 2'b10;
    tick(5);
    check("clean.e5_pressed", 32'(pressed), 32'd0);
    tick(1);
    check("clean.e6_pressed", 32'(pressed), 32'b01);
    check("clean.e6_press", 32'(press_pulse), 32'b01);
    check("clean.e6_any", 32'(any_event), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      logic rep_e, rel_e;
      tick(1);
      rep_e = (k >= 10) && ((k - 10) % 3 == 0) && (k < 37);
      rel_e = (k == 37);
      check($sformatf("rep.k%0d_press", k), 32'(press_pulse), 32'd0);
      check($sformatf("rep.k%0d_rep", k), 32'(repeat_pulse), 32'({1'b0, rep_e}));
      check($sformatf("rep.k%0d_rel", k), 32'(release_pulse), 32'({1'b0, rel_e}));
      check($sformatf("rep.k%0d_pressed", k), 32'(pressed), 32'({1'b0, k < 37}));
      check($sformatf("rep.k%0d_any", k), 32'(any_event), 32'(rep_e | rel_e));
      if (k == 31) pin = 2'b11;
    end
    tick(4);

    // Bounce: low 3, high 1, low 2, then high -> nothing accepted
    pin = 2'b10; tick(3);
    pin = 2'b11; tick(1);
    pin = 2'b10; tick(2);
    pin = 2'b11;
    for (int k = 0; k < 8; k++) begin
      check_quiet($sformatf("bounce.c%0d", k));
      tick(1);
    end
    pin = 2'b10;
    tick(5);
    check("bounce.e5_pressed", 32'(pressed), 32'd0);
    tick(1);
    check("bounce.e6_press", 32'(press_pulse), 32'b01);
    pin = 2'b11;
    tick(5);
    check("bounce.rel_early", 32'(release_pulse), 32'd0);
    tick(1);
    check("bounce.rel", 32'(release_pulse), 32'b01);
    check("bounce.rel_pressed", 32'(pressed), 32'd0);
    tick(4);

    // Repeat disabled: one repeat at +10, nothing after
    pin_nr = 2'b10;
    tick(6);
    check("norep.press", 32'(press_nr), 32'b01);
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      check($sformatf("norep.k%0d", k), 32'(repeat_nr), 32'({1'b0, k == 10}));
    end
    check("norep.pressed", 32'(pressed_nr), 32'b01);
    pin_nr = 2'b11;
    tick(6);
    check("norep.rel", 32'(release_nr), 32'b01);
    tick(4);

    // Simultaneous press on both channels
    pin = 2'b00;
    tick(5);
    check("simul.e5", 32'(press_pulse), 32'd0);
    tick(1);
    check("simul.press", 32'(press_pulse), 32'b11);
    check("simul.any", 32'(any_event), 32'd1);
    tick(1);
    check("simul.press_off", 32'(press_pulse), 32'd0);
    check("simul.any_off", 32'(any_event), 32'd0);
    pin = 2'b11;
    tick(6);
    check("simul.rel", 32'(release_pulse), 32'b11);
    tick(4);

    // Reset during REPEAT with pin held
    pin = 2'b10;
    tick(6);
    check("rst.press", 32'(press_pulse), 32'b01);
    tick(12);
    check("rst.before", 32'(pressed), 32'b01);
    rst_n = 1'b0;
    #1;
    check_quiet("rst.async");
    tick(2);
    check_quiet("rst.held");
    rst_n = 1'b1;
    tick(5);
    check("rst.e5", 32'(pressed), 32'd0);
    tick(1);
    check("rst.e6_press", 32'(press_pulse), 32'b01);
    check("rst.e6_pressed", 32'(pressed), 32'b01);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check($sformatf("rst.rep_k%0d", k), 32'(repeat_pulse), 32'({1'b0, k == 10}));
    end
    pin = 2'b11;
    tick(8);
    check("rst.final_pressed", 32'(pressed), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Input-side counterpart of the front-panel LED stretcher: cleans up N open-drain pushbutton/switch inputs for the interface-board FPGA.
- Each channel is an independent per-channel state machine:
  - synchronizes the asynchronous pin;
  - rejects bounce and glitches shorter than a programmable window;
  - presents a debounced level plus single-cycle press, release and auto-repeat event pulses to the control logic.

Parameters:
- N, 4, number of independent input channels.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (pull-up/open-drain); 0 = pin reads 1 when pressed.
- DEBOUNCE_CYCLES, 20000, consecutive clk cycles a changed level must hold before acceptance; legal range ≥2.
- HOLD_CYCLES, 16000000, cycles from accepted press to first repeat pulse; legal range ≥1.
- REPEAT_CYCLES, 4000000, cycles between subsequent repeat pulses; 0 disables repeat entirely.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pin  in  N  raw button inputs, asynchronous to clk.
- pressed  out  N  debounced state, 1 = pressed.
- press_pulse  out  N  one-cycle pulse when pressed rises.
- release_pulse  out  N  one-cycle pulse when pressed falls.
- repeat_pulse  out  N  one-cycle auto-repeat pulse while held.
- any_event  out  1  OR of all press/release/repeat pulse bits, same cycle.

Behaviour:
- Reset:
  - one clock; reset is asynchronous and active-low (rst_n); all state clears immediately on assertion.
  - 2-FF synchronizer flops reset to the inactive pin level (1 if ACTIVE_LOW, else 0).
  - Counters reset to 0; pressed = 0; all pulse outputs = 0; any_event = 0.
- Synchronizer, per channel:
  - s1 <= pin, s2 <= s1.
  - level = s2 XOR ACTIVE_LOW (1 = pressed). Never use s1 or pin directly.
- Debounce counter dcnt, per channel; width = clog2(DEBOUNCE_CYCLES), evaluated each edge:
  - if level == pressed: dcnt <= 0.
  - else if dcnt == DEBOUNCE_CYCLES-1: pressed <= level, dcnt <= 0, and fire press_pulse (if level = 1) or release_pulse (if level = 0) on the same edge.
  - else: dcnt <= dcnt+1.
- Latency and glitch rejection:
  - Take edge 1 as the first edge at which s1 samples the new pin value. pressed and the matching pulse go high after edge DEBOUNCE_CYCLES+2.
  - A return to the old level before that edge clears dcnt; no output changes.
- Repeat FSM per channel; states IDLE, HOLD, REPEAT; hold counter hcnt wide enough for max(HOLD_CYCLES, REPEAT_CYCLES):
  - IDLE: pressed = 0. On the edge pressed rises -> HOLD, hcnt <= 0.
  - HOLD: hcnt++ each edge. When hcnt == HOLD_CYCLES-1: repeat_pulse, hcnt <= 0; then -> REPEAT if REPEAT_CYCLES > 0, else stay in HOLD with hcnt frozen and no further pulses.
  - REPEAT: hcnt++ each edge. When hcnt == REPEAT_CYCLES-1: repeat_pulse, hcnt <= 0.
  - From any state, on the edge pressed falls -> IDLE, hcnt <= 0. repeat_pulse never coincides with release_pulse; release wins.
  - hcnt keeps running while a release is pending in dcnt (pressed still 1).
- Pulses:
  - All pulse outputs are registered, high for exactly one cycle.
  - press_pulse and repeat_pulse are never high together on one channel.
  - any_event is combinational OR of registered pulses.
- Channels are fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
- Pin held pressed through reset release: treated as a new press; pressed and press_pulse assert DEBOUNCE_CYCLES+2 edges after rst_n deassertion.
- Reset asserted mid-debounce or mid-repeat: no pulse is emitted, and pressed drops asynchronously.

Test Plan (bench parameters N=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3):
- Clean press: pin[0] 1->0 before edge 1, held -> pressed[0] and press_pulse[0] high after edge 6; press_pulse low after edge 7; any_event mirrors it; channel 1 quiet.
- Bounce: pin[0] low for 3 cycles, high 1, low 2, high -> no change on any output; then low for 6 cycles -> press accepted exactly 6 edges after the final falling pin.
- Auto-repeat: hold pin[0] low 30 cycles after acceptance -> repeat_pulse[0] 10 cycles after press_pulse, then every 3 cycles (cycles +10, +13, +16, ...); release -> release_pulse[0] 6 edges after pin rises, no repeat_pulse that cycle.
- REPEAT_CYCLES=0 rerun: hold 40 cycles -> exactly one repeat_pulse at +10, none after.
- Simultaneous: both pins fall on the same cycle -> press_pulse = 2'b11 on the same cycle; any_event high one cycle.
- Reset mid-operation: assert rst_n low during REPEAT with pin held low -> pressed = 0 immediately; deassert -> press_pulse 6 edges later, repeat_pulse 10 cycles after that.
